score_counter: RTL and testbench



---
 rtl/score_pkg.sv | 14 +
 rtl/sat_adder.sv | 19 +
 rtl/score_counter.sv | 51 +++++
 tb/tb_score_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared score definitions: increment width, default limit and the score width
// helper reused by the display/BCD blocks.
package score_pkg;

    localparam int SCORE_INC_WIDTH   = 7;
    localparam int DEFAULT_MAX_SCORE = 9999;

    typedef logic [SCORE_INC_WIDTH-1:0] score_inc_t;

    function automatic int score_width(input int max);
        return $clog2(max);
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational saturating adder: one extra bit of sum headroom, then a clamp to LIMIT.
module sat_adder #(
    parameter int WIDTH    = 14,
    parameter int IN_WIDTH = 7,
    parameter int LIMIT    = 9999
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [IN_WIDTH-1:0] b,
    output logic [WIDTH:0]      sum,
    output logic                saturated,
    output logic [WIDTH-1:0]    result
);

    // The WIDTH+1 bit sum can never overflow, so a single compare catches every clamp case.
    assign sum       = {1'b0, a} + (WIDTH+1)'(b);
    assign saturated = (sum > (WIDTH+1)'(LIMIT));
    assign result    = saturated ? WIDTH'(LIMIT) : sum[WIDTH-1:0];

endmodule

// File: rtl/score_counter.sv
// Registered saturating score total; score_increase is sampled every cycle with
// no handshake, and a held value is added again on each edge.
module score_counter
    import score_pkg::*;
#(
    parameter int MAX_SCORE   = DEFAULT_MAX_SCORE,
    parameter int SCORE_WIDTH = score_width(MAX_SCORE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SCORE_INC_WIDTH-1:0] score_increase,
    output logic [SCORE_WIDTH-1:0]     score_count
);

    // A power-of-two limit would need one more bit than $clog2 provides.
    if ((MAX_SCORE & (MAX_SCORE - 1)) == 0) begin : g_bad_max
        $error("score_counter: MAX_SCORE (%0d) must not be a power of two", MAX_SCORE);
    end
    if (SCORE_WIDTH < SCORE_INC_WIDTH) begin : g_bad_width
        $error("score_counter: SCORE_WIDTH (%0d) narrower than the increment", SCORE_WIDTH);
    end

    logic [SCORE_WIDTH:0]   sum_full;
    logic                   sat_flag;
    logic [SCORE_WIDTH-1:0] sat_result;
    logic                   unused_sat;

    sat_adder #(
        .WIDTH    (SCORE_WIDTH),
        .IN_WIDTH (SCORE_INC_WIDTH),
        .LIMIT    (MAX_SCORE)
    ) u_sat_adder (
        .a         (score_count),
        .b         (score_increase),
        .sum       (sum_full),
        .saturated (sat_flag),
        .result    (sat_result)
    );

    assign unused_sat = ^{sum_full, sat_flag};

    // Reset takes the constant branch, so an X on score_increase never reaches the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_count <= '0;
        end else begin
            score_count <= sat_result;
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: default limit and a MAX_SCORE=500 instance, both
// checked against a plain arithmetic model of the saturating total.
module tb_score_counter;

    logic        clk;
    logic        rst;
    logic [6:0]  score_increase;
    logic [13:0] score_count;
    logic [8:0]  score_small;

    int n_checks;
    int n_fail;
    int exp_main;
    int exp_small;

    score_counter dut (
        .clk            (clk),
        .rst            (rst),
        .score_increase (score_increase),
        .score_count    (score_count)
    );

    score_counter #(.MAX_SCORE(500)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .score_increase (score_increase),
        .score_count    (score_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle and advance the reference totals; sampling happens 1 time unit after the edge.
    task automatic cycle(input int inc, input bit r);
        score_increase = 7'(inc);
        rst            = r;
        @(posedge clk);
        #1;
        if (r) begin
            exp_main  = 0;
            exp_small = 0;
        end else begin
            exp_main  = (exp_main + inc > 9999) ? 9999 : exp_main + inc;
            exp_small = (exp_small + inc > 500) ? 500 : exp_small + inc;
        end
    endtask

    task automatic test_reset();
        cycle(0, 1);
        cycle(55, 1);
        n_checks++;
        if (score_count !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_main: got %0d want 0", score_count);
        end
        n_checks++;
        if (score_small !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_small: got %0d want 0", score_small);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0);
            n_checks++;
            if (score_count !== 14'd0) begin
                n_fail++;
                $display("FAIL zero_hold cycle %0d: got %0d want 0", i, score_count);
            end
        end
    endtask

    task automatic test_ramp();
        cycle(0, 1);
        for (int i = 1; i <= 10; i++) begin
            cycle(i, 0);
            n_checks++;
            if (score_count !== 14'(i * (i + 1) / 2)) begin
                n_fail++;
                $display("FAIL ramp step %0d: got %0d want %0d", i, score_count, i * (i + 1) / 2);
            end
        end
    endtask

    task automatic test_saturate_hold();
        cycle(0, 1);
        for (int i = 1; i <= 101; i++) begin
            cycle(99, 0);
            n_checks++;
            if (score_count !== 14'(99 * i)) begin
                n_fail++;
                $display("FAIL hold99 cycle %0d: got %0d want %0d", i, score_count, 99 * i);
            end
        end
        cycle(99, 0);
        n_checks++;
        if (score_count !== 14'd9999) begin
            n_fail++;
            $display("FAIL at_max_99: got %0d want 9999", score_count);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(127, 0);
            n_checks++;
            if (score_count !== 14'd9999) begin
                n_fail++;
                $display("FAIL at_max_127 cycle %0d: got %0d want 9999", i, score_count);
            end
        end
    endtask

    task automatic test_approach();
        cycle(0, 1);
        for (int i = 0; i < 100; i++) cycle(99, 0);
        cycle(50, 0);
        n_checks++;
        if (score_count !== 14'd9950) begin
            n_fail++;
            $display("FAIL approach_9950: got %0d want 9950", score_count);
        end
        cycle(60, 0);
        n_checks++;
        if (score_count !== 14'd9999) begin
            n_fail++;
            $display("FAIL approach_clamp: got %0d want 9999", score_count);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1);
        for (int i = 0; i < 20; i++) cycle(100, 0);
        cycle(50, 0);
        n_checks++;
        if (score_count !== 14'd2050) begin
            n_fail++;
            $display("FAIL mid_2050: got %0d want 2050", score_count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(95, 1);
            n_checks++;
            if (score_count !== 14'd0) begin
                n_fail++;
                $display("FAIL mid_rst cycle %0d: got %0d want 0", i, score_count);
            end
        end
        cycle(5, 0);
        n_checks++;
        if (score_count !== 14'd5) begin
            n_fail++;
            $display("FAIL mid_resume: got %0d want 5", score_count);
        end
    endtask

    task automatic test_simultaneous();
        cycle(40, 0);
        cycle(127, 1);
        n_checks++;
        if (score_count !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_with_127: got %0d want 0", score_count);
        end
        score_increase = 7'bx;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (score_count !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_with_x: got %b want 0", score_count);
        end
    endtask

    task automatic test_small_max();
        cycle(0, 1);
        for (int i = 1; i <= 6; i++) begin
            cycle(127, 0);
            n_checks++;
            if (score_small !== 9'(exp_small)) begin
                n_fail++;
                $display("FAIL small_max step %0d: got %0d want %0d", i, score_small, exp_small);
            end
        end
        n_checks++;
        if (score_small !== 9'd500) begin
            n_fail++;
            $display("FAIL small_max_limit: got %0d want 500", score_small);
        end
    endtask

    task automatic test_random();
        int inc;
        bit r;
        cycle(0, 1);
        for (int i = 0; i < 400; i++) begin
            inc = $urandom_range(0, 127);
            r   = ($urandom_range(0, 99) < 3);
            cycle(inc, r);
            n_checks++;
            if (score_count !== 14'(exp_main)) begin
                n_fail++;
                $display("FAIL random_main cycle %0d: got %0d want %0d", i, score_count, exp_main);
            end
            n_checks++;
            if (score_small !== 9'(exp_small)) begin
                n_fail++;
                $display("FAIL random_small cycle %0d: got %0d want %0d", i, score_small, exp_small);
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        exp_main       = 0;
        exp_small      = 0;
        rst            = 1'b1;
        score_increase = '0;
        test_reset();
        test_ramp();
        test_saturate_hold();
        test_approach();
        test_reset_mid();
        test_simultaneous();
        test_small_max();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
